mult_pipe_bw: RTL

Parametrised pipelined integer multiplier, successor to the fixed-width combinational Baugh-Wooley multipliers.
- Per-transaction signed/unsigned operand mode.
- Valid/ready handshake on input and output.
- Configurable number of register stages after the multiply core.
- Sits between operand FIFOs and downstream datapath (MAC/accumulator blocks), sustaining one product per cycle under no backpressure.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_bw_core.sv | 55 +++++
 rtl/mult_pipe_bw.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the pipelined Baugh-Wooley multiplier: operand modes,
// default sizes and the product-width helper.
package mult_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 2;

    // Encoded as {a_signed, b_signed}
    typedef enum logic [1:0] {
        MODE_UU = 2'b00,
        MODE_US = 2'b01,
        MODE_SU = 2'b10,
        MODE_SS = 2'b11
    } mode_e;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mult_bw_core.sv
// Combinational Baugh-Wooley multiplier on (WIDTH+1)-bit extended operands,
// which covers all four signed/unsigned mode combinations with one array.
module mult_bw_core
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic                     a_signed,
    input  logic                     b_signed,
    output logic [prod_w(WIDTH)-1:0] product
);

    localparam int N      = WIDTH + 1;
    localparam int PW     = prod_w(WIDTH);
    localparam int LEVELS = $clog2(N + 1);
    localparam int NT     = 1 << LEVELS;

    mode_e        mode;
    logic [N-1:0] ax;
    logic [N-1:0] bx;

    assign mode = mode_e'({a_signed, b_signed});
    assign ax   = {(mode inside {MODE_SU, MODE_SS}) & a[WIDTH-1], a};
    assign bx   = {(mode inside {MODE_US, MODE_SS}) & b[WIDTH-1], b};

    logic [PW-1:0] t [NT];
    logic [N-1:0]  r;
    logic          pp;

    // Everything is kept modulo 2^PW; the 2^(2N-1) correction term lies above
    // the kept bits and is dropped.
    always_comb begin
        t  = '{default: '0};
        r  = '0;
        pp = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                pp   = ax[j] & bx[i];
                r[j] = ((i == N - 1) != (j == N - 1)) ? ~pp : pp;
            end
            t[i] = {{(PW - N){1'b0}}, r} << i;
        end
        t[N] = {{(PW - 1){1'b0}}, 1'b1} << N;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            for (int i = 0; i < (NT >> (lvl + 1)); i++) begin
                t[i] = t[2*i] + t[2*i+1];
            end
        end
    end

    assign product = t[0];

endmodule

// File: rtl/mult_pipe_bw.sv
// Pipelined multiplier with bubble-collapsing valid/ready slots after the core.
// Optional sideband tag ports/registers enabled by MULT_PIPE_TAG_EN.
module mult_pipe_bw
    import mult_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
`ifdef MULT_PIPE_TAG_EN
    ,
    parameter int TAG_W  = 4
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     in_a_signed,
    input  logic                     in_b_signed,
`ifdef MULT_PIPE_TAG_EN
    input  logic [TAG_W-1:0]         in_tag,
    output logic [TAG_W-1:0]         out_tag,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [prod_w(WIDTH)-1:0] out_product
);

    localparam int PW = prod_w(WIDTH);

    logic [PW-1:0]     core_prod;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic              empty;

    mult_bw_core #(.WIDTH(WIDTH)) u_core (
        .a        (in_a),
        .b        (in_b),
        .a_signed (in_a_signed),
        .b_signed (in_b_signed),
        .product  (core_prod)
    );

    // A slot may advance if downstream accepts or any slot at or after it is empty.
    always_comb begin
        adv   = '0;
        empty = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            empty = 1'b0;
            for (int j = k; j < STAGES; j++) begin
                empty = empty | ~vld[j];
            end
            adv[k] = out_ready | empty;
        end
    end

    assign in_ready = adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        logic          vld_p;
        logic          vld_d;
        logic [PW-1:0] prod_p;
        logic [PW-1:0] prod_d;
`ifdef MULT_PIPE_TAG_EN
        logic [TAG_W-1:0] tag_p;
        logic [TAG_W-1:0] tag_d;
`endif

        if (k == 0) begin : g_src
            assign vld_d  = in_valid;
            assign prod_d = core_prod;
`ifdef MULT_PIPE_TAG_EN
            assign tag_d  = in_tag;
`endif
        end else begin : g_src
            assign vld_d  = g_slot[k-1].vld_p;
            assign prod_d = g_slot[k-1].prod_p;
`ifdef MULT_PIPE_TAG_EN
            assign tag_d  = g_slot[k-1].tag_p;
`endif
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) vld_p <= 1'b0;
            else if (adv[k]) vld_p <= vld_d;
        end

        // Only the output slot is visible at reset, so only it gets a data reset.
        if (k == STAGES - 1) begin : g_out
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prod_p <= '0;
`ifdef MULT_PIPE_TAG_EN
                    tag_p  <= '0;
`endif
                end else if (adv[k]) begin
                    prod_p <= prod_d;
`ifdef MULT_PIPE_TAG_EN
                    tag_p  <= tag_d;
`endif
                end
            end
        end else begin : g_mid
            always_ff @(posedge clk) begin
                if (adv[k]) begin
                    prod_p <= prod_d;
`ifdef MULT_PIPE_TAG_EN
                    tag_p  <= tag_d;
`endif
                end
            end
        end

        assign vld[k] = vld_p;
    end

    assign out_valid   = vld[STAGES-1];
    assign out_product = g_slot[STAGES-1].prod_p;
`ifdef MULT_PIPE_TAG_EN
    assign out_tag     = g_slot[STAGES-1].tag_p;
`endif

endmodule
